mem_port_arbiter: RTL and testbench

//  Shares one single-beat downstream memory port between the CPU's instruction-fetch (im_*) and data (dm_*) ports.

---
 rtl/mem_port_arbiter_pkg.sv | 25 ++
 rtl/mem_port_arbiter_watchdog.sv | 39 +++
 rtl/mem_port_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Purpose : shared types and constants for the memory port arbiter.
// Contents: FSM state encoding, read byte-enable pattern, and the width
//           helper used to size the response watchdog counter.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    D_REQ,
    D_RESP,
    I_REQ,
    I_RESP,
    DONE
  } arb_state_e;

  // Byte enables are active-low, so a read enables no byte lanes.
  localparam logic [3:0] WEB_READ = 4'hF;

  // Bits needed to hold 0..timeout inclusive (the counter saturates at timeout).
  function automatic int cnt_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// Purpose : saturating response-wait counter for the arbiter's *_RESP states.
// Latency : expire is combinational from the count register.
// Ports   : clk, rst (async active-low), clr (load zero, wins over en),
//           en (count one waiting cycle), expire (this is the LIMIT-th wait cycle).
module bus_watchdog
  import mem_arb_pkg::*;
#(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int W = cnt_width(LIMIT);
  localparam logic [W-1:0] SAT  = W'(LIMIT);
  localparam logic [W-1:0] LAST = (LIMIT > 0) ? W'(LIMIT - 1) : '0;

  logic [W-1:0] count;

  // count = number of completed waiting cycles since the clear; it stops at
  // SAT so a long stall can never wrap it back into the "still waiting" range.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != SAT)) begin
      count <= count + 1'b1;
    end
  end

  // The cycle whose count is LIMIT-1 is the LIMIT-th cycle spent waiting;
  // a response arriving in that same cycle still beats the timeout upstream.
  assign expire = (count >= LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose : shares one single-beat memory port between CPU fetch (im_*) and
//           data (dm_*) ports; DM is served before IM once per pipeline step.
// Latency : fetch-only step 4 cycles min, data+fetch 6 cycles min; bus_stall
//           is low only in the single DONE cycle that ends each step.
// Backpressure: mem_req is held with stable address/data until mem_ready;
//           a missing mem_rvalid is aborted after TIMEOUT cycles (bus_err).
// Ports   : clk, rst (async active-low); CPU side im_read_mem/im_addr,
//           dm_read_mem/dm_write_mem/dm_addr/dm_web/dm_datain in,
//           im_dataout/dm_dataout/bus_stall/bus_err out; memory side
//           mem_req/mem_we/mem_web/mem_addr/mem_wdata out,
//           mem_ready/mem_rvalid/mem_rdata in.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              im_read_mem,
  input  logic [ADDR_W-1:0] im_addr,
  input  logic              dm_read_mem,
  input  logic              dm_write_mem,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [3:0]        dm_web,
  input  logic [DATA_W-1:0] dm_datain,
  output logic [DATA_W-1:0] im_dataout,
  output logic [DATA_W-1:0] dm_dataout,
  output logic              bus_stall,
  output logic              bus_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_web,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e state, state_nxt;

  // Per-step snapshot of the CPU request; only these drive the memory side.
  logic              snap_im_rd;
  logic [ADDR_W-1:0] snap_im_addr;
  logic              snap_dm_rd;
  logic              snap_dm_wr;
  logic [ADDR_W-1:0] snap_dm_addr;
  logic [3:0]        snap_dm_web;
  logic [DATA_W-1:0] snap_dm_wdata;

  logic in_resp;
  logic dm_phase;
  logic dm_is_load;
  logic expire;
  logic resp_done;
  logic rsp_timeout;

  assign in_resp    = (state == D_RESP) || (state == I_RESP);
  assign dm_phase   = (state == D_REQ) || (state == D_RESP);
  // When both load and store are flagged the store wins, so no load result.
  assign dm_is_load = snap_dm_rd && !snap_dm_wr;
  assign resp_done  = in_resp && (mem_rvalid || expire);
  // A response coinciding with expiry counts as a normal completion.
  assign rsp_timeout = in_resp && expire && !mem_rvalid;

  // ---------------------------------------------------------------- FSM
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (dm_read_mem || dm_write_mem) begin
          state_nxt = D_REQ;
        end else if (im_read_mem) begin
          state_nxt = I_REQ;
        end else begin
          state_nxt = DONE;
        end
      end
      D_REQ: begin
        if (mem_ready) begin
          state_nxt = D_RESP;
        end
      end
      D_RESP: begin
        if (resp_done) begin
          state_nxt = snap_im_rd ? I_REQ : DONE;
        end
      end
      I_REQ: begin
        if (mem_ready) begin
          state_nxt = I_RESP;
        end
      end
      I_RESP: begin
        if (resp_done) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ----------------------------------------------------------- snapshot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap_im_rd    <= 1'b0;
      snap_im_addr  <= '0;
      snap_dm_rd    <= 1'b0;
      snap_dm_wr    <= 1'b0;
      snap_dm_addr  <= '0;
      snap_dm_web   <= WEB_READ;
      snap_dm_wdata <= '0;
    end else if (state == IDLE) begin
      snap_im_rd    <= im_read_mem;
      snap_im_addr  <= im_addr;
      snap_dm_rd    <= dm_read_mem;
      snap_dm_wr    <= dm_write_mem;
      snap_dm_addr  <= dm_addr;
      snap_dm_web   <= dm_web;
      snap_dm_wdata <= dm_datain;
    end
  end

  // ------------------------------------------------------ result latches
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      im_dataout <= '0;
      dm_dataout <= '0;
      bus_err    <= 1'b0;
    end else begin
      if ((state == D_RESP) && dm_is_load) begin
        if (mem_rvalid) begin
          dm_dataout <= mem_rdata;
        end else if (expire) begin
          dm_dataout <= '0;
        end
      end
      if (state == I_RESP) begin
        if (mem_rvalid) begin
          im_dataout <= mem_rdata;
        end else if (expire) begin
          im_dataout <= '0;
        end
      end
      if (rsp_timeout) begin
        bus_err <= 1'b1;
      end
    end
  end

  // ------------------------------------------------------- memory side
  // Decoded from state and snapshot registers, so values stay put for the
  // whole request phase regardless of what the CPU does meanwhile.
  assign mem_req   = (state == D_REQ) || (state == I_REQ);
  assign mem_we    = dm_phase && snap_dm_wr;
  assign mem_web   = mem_we ? snap_dm_web : WEB_READ;
  assign mem_addr  = dm_phase ? snap_dm_addr : snap_im_addr;
  assign mem_wdata = snap_dm_wdata;

  assign bus_stall = (state != DONE);

  // Counter restarts on the accept edge, i.e. on entry to the *_RESP state.
  bus_watchdog #(
    .LIMIT (TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (mem_req && mem_ready),
    .en     (in_resp && !mem_rvalid),
    .expire (expire)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        im_read_mem = 1'b0;
  logic [31:0] im_addr = '0;
  logic        dm_read_mem = 1'b0;
  logic        dm_write_mem = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [3:0]  dm_web = 4'hF;
  logic [31:0] dm_datain = '0;
  logic [31:0] im_dataout, dm_dataout;
  logic        bus_stall, bus_err;
  logic        mem_req, mem_we;
  logic [3:0]  mem_web;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  web;
    logic [31:0] wdata;
    logic [31:0] rdata;   // data (or ack payload) the bench returns for this access
  } req_t;

  typedef struct {
    int          cycles;  // cycle index (IDLE = 1) at which bus_stall drops
    logic [31:0] im;
    logic [31:0] dm;
    logic        err;
  } res_t;

  req_t req_q[$];
  res_t res_q[$];

  mem_port_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .im_read_mem  (im_read_mem),
    .im_addr      (im_addr),
    .dm_read_mem  (dm_read_mem),
    .dm_write_mem (dm_write_mem),
    .dm_addr      (dm_addr),
    .dm_web       (dm_web),
    .dm_datain    (dm_datain),
    .im_dataout   (im_dataout),
    .dm_dataout   (dm_dataout),
    .bus_stall    (bus_stall),
    .bus_err      (bus_err),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_web      (mem_web),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ready    (mem_ready),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic set_cpu(input logic ird, input logic [31:0] ia, input logic drd,
                         input logic dwr, input logic [31:0] da, input logic [3:0] web,
                         input logic [31:0] din);
    im_read_mem  = ird;
    im_addr      = ia;
    dm_read_mem  = drd;
    dm_write_mem = dwr;
    dm_addr      = da;
    dm_web       = web;
    dm_datain    = din;
  endtask

  // Plays one pipeline step from IDLE: answers requests from req_q, scrambles
  // CPU inputs after IDLE, sprays stray mem_rvalid outside response windows,
  // and checks the DONE cycle against res_q. Entered and left on a negedge.
  task automatic run_step(input string name, input int ready_wait,
                          input int rsp_wait, input bit drop);
    bit   done = 0;
    bit   pend = 0;
    int   wcnt = 0;
    int   rcnt = 0;
    req_t cur;
    res_t exp_r;
    for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
      mem_ready  = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
      if (cyc == 2) begin
        set_cpu(1'($urandom), $urandom, 1'($urandom), 1'($urandom), $urandom,
                4'($urandom), $urandom);
      end
      if (bus_stall === 1'b0) begin
        done = 1;
        n_cmp++;
        if (res_q.size() == 0) begin
          n_err++;
          $display("FAIL %s_result: DONE reached, no result expected", name);
        end else begin
          exp_r = res_q.pop_front();
          if (cyc !== exp_r.cycles) begin
            n_err++;
            $display("FAIL %s_latency: got %0d cycles, want %0d", name, cyc, exp_r.cycles);
          end
          n_cmp++;
          if (im_dataout !== exp_r.im) begin
            n_err++;
            $display("FAIL %s_im_dataout: got %h, want %h", name, im_dataout, exp_r.im);
          end
          n_cmp++;
          if (dm_dataout !== exp_r.dm) begin
            n_err++;
            $display("FAIL %s_dm_dataout: got %h, want %h", name, dm_dataout, exp_r.dm);
          end
          n_cmp++;
          if (bus_err !== exp_r.err) begin
            n_err++;
            $display("FAIL %s_bus_err: got %b, want %b", name, bus_err, exp_r.err);
          end
        end
        if (!pend) begin
          mem_rvalid = 1'b1;
          mem_rdata  = 32'hBAD0_BAD0;
        end
      end else if (mem_req === 1'b1) begin
        n_cmp++;
        if (req_q.size() == 0) begin
          n_err++;
          $display("FAIL %s_extra_req: unexpected request addr %h", name, mem_addr);
        end else begin
          cur = req_q[0];
          if (mem_addr !== cur.addr || mem_we !== cur.we || mem_web !== cur.web ||
              (cur.we && mem_wdata !== cur.wdata)) begin
            n_err++;
            $display("FAIL %s_req_c%0d: got addr %h we %b web %b wdata %h, want addr %h we %b web %b wdata %h",
                     name, cyc, mem_addr, mem_we, mem_web, mem_wdata,
                     cur.addr, cur.we, cur.web, cur.wdata);
          end
          if (wcnt < ready_wait) begin
            wcnt++;
          end else begin
            mem_ready = 1'b1;
            void'(req_q.pop_front());
            pend = 1;
            rcnt = 0;
            wcnt = 0;
          end
        end
      end else if (pend) begin
        if (!drop && rcnt == rsp_wait) begin
          mem_rvalid = 1'b1;
          mem_rdata  = cur.rdata;
          pend       = 0;
        end else begin
          rcnt++;
        end
      end else begin
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAD0_BAD0;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL %s_no_done: bus_stall never dropped within 60 cycles", name);
    end else if (req_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_missing_req: %0d requests never issued, want 0", name, req_q.size());
    end
    req_q.delete();
    res_q.delete();
  endtask

  task automatic test_reset;
    logic [135:0] got;
    #1;
    got = {bus_stall, mem_req, mem_we, bus_err, mem_web, im_dataout, dm_dataout, mem_addr, mem_wdata};
    n_cmp++;
    if (got !== {1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 128'h0}) begin
      n_err++;
      $display("FAIL reset_values: got %h, want %h", got, {1'b1, 3'b000, 4'hF, 128'h0});
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_fetch_only;
    set_cpu(1, 32'h0000_0004, 0, 0, 32'h0, 4'hF, 32'h0);
    req_q.push_back('{32'h0000_0004, 1'b0, 4'hF, 32'h0, 32'h0000_0013});
    res_q.push_back('{4, 32'h0000_0013, 32'h0, 1'b0});
    run_step("fetch", 0, 0, 0);
  endtask

  task automatic test_load_fetch;
    set_cpu(1, 32'h0000_0008, 1, 0, 32'h0001_0008, 4'hF, 32'h0);
    req_q.push_back('{32'h0001_0008, 1'b0, 4'hF, 32'h0, 32'hCAFE_F00D});
    req_q.push_back('{32'h0000_0008, 1'b0, 4'hF, 32'h0, 32'h0000_0093});
    res_q.push_back('{6, 32'h0000_0093, 32'hCAFE_F00D, 1'b0});
    run_step("load_fetch", 0, 0, 0);
  endtask

  task automatic test_store_fetch;
    // read and write both flagged: the write must win
    set_cpu(1, 32'h0000_000C, 1, 1, 32'h0001_0010, 4'b1100, 32'h1234_5678);
    req_q.push_back('{32'h0001_0010, 1'b1, 4'b1100, 32'h1234_5678, 32'hDEAD_BEEF});
    req_q.push_back('{32'h0000_000C, 1'b0, 4'hF, 32'h0, 32'h0000_0113});
    res_q.push_back('{6, 32'h0000_0113, 32'hCAFE_F00D, 1'b0});
    run_step("store_fetch", 0, 0, 0);
  endtask

  task automatic test_no_request;
    set_cpu(0, 32'h0000_0100, 0, 0, 32'h0000_0200, 4'h0, 32'hFFFF_FFFF);
    res_q.push_back('{2, 32'h0000_0113, 32'hCAFE_F00D, 1'b0});
    run_step("no_request", 0, 0, 0);
  endtask

  task automatic test_ready_stall;
    set_cpu(1, 32'h0000_0010, 0, 0, 32'h0, 4'hF, 32'h0);
    req_q.push_back('{32'h0000_0010, 1'b0, 4'hF, 32'h0, 32'h0000_0517});
    res_q.push_back('{14, 32'h0000_0517, 32'hCAFE_F00D, 1'b0});
    run_step("ready_stall", 10, 0, 0);
  endtask

  task automatic test_rvalid_at_expiry;
    set_cpu(1, 32'h0000_0014, 0, 0, 32'h0, 4'hF, 32'h0);
    req_q.push_back('{32'h0000_0014, 1'b0, 4'hF, 32'h0, 32'h1111_1111});
    res_q.push_back('{11, 32'h1111_1111, 32'hCAFE_F00D, 1'b0});
    run_step("rvalid_at_expiry", 0, 7, 0);
  endtask

  task automatic test_timeout;
    set_cpu(1, 32'h0000_0018, 0, 0, 32'h0, 4'hF, 32'h0);
    req_q.push_back('{32'h0000_0018, 1'b0, 4'hF, 32'h0, 32'h2222_2222});
    res_q.push_back('{11, 32'h0, 32'hCAFE_F00D, 1'b1});
    run_step("timeout", 0, 0, 1);
  endtask

  task automatic test_reset_mid;
    logic [135:0] got;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    set_cpu(1, 32'h0000_0020, 1, 0, 32'h0002_0000, 4'hF, 32'h0);
    @(negedge clk);
    n_cmp++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0002_0000) begin
      n_err++;
      $display("FAIL rstmid_dreq: got req %b addr %h, want req 1 addr 00020000", mem_req, mem_addr);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    n_cmp++;
    if (mem_req !== 1'b0 || bus_stall !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_dresp: got req %b stall %b, want req 0 stall 1", mem_req, bus_stall);
    end
    #2 rst = 1'b0;
    #1;
    got = {bus_stall, mem_req, mem_we, bus_err, mem_web, im_dataout, dm_dataout, mem_addr, mem_wdata};
    n_cmp++;
    if (got !== {1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 128'h0}) begin
      n_err++;
      $display("FAIL rstmid_values: got %h, want %h", got, {1'b1, 3'b000, 4'hF, 128'h0});
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_after_reset;
    set_cpu(1, 32'h0000_0040, 0, 0, 32'h0, 4'hF, 32'h0);
    req_q.push_back('{32'h0000_0040, 1'b0, 4'hF, 32'h0, 32'h0000_0067});
    res_q.push_back('{4, 32'h0000_0067, 32'h0, 1'b0});
    run_step("after_reset", 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_load_fetch();
    test_store_fetch();
    test_no_request();
    test_ready_stall();
    test_rvalid_at_expiry();
    test_timeout();
    test_reset_mid();
    test_after_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
